// File: rtl/mdu_unit.sv
// Execute-stage multiply/divide unit owning HI/LO.
// The result is computed at the start edge, held as pending, and committed after a fixed latency.
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A1,
    input  logic [31:0] A2,
    input  logic [3:0]  mdu_op,
    input  logic        start,
    output logic        busy,
    output logic [31:0] mdu_res,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] count, count_nx;
    logic [31:0]   hi, lo, pend_hi, pend_lo;
    logic          pend_we;
    logic          accept, commit, is_md, is_mult;

    logic [63:0]   prod_s, prod_u;
    logic          div_signed, neg_a, neg_b;
    logic [31:0]   mag_a, mag_b, divisor, q_mag, r_mag, quot, rem;

    assign is_mult = (mdu_op == OP_MULT) || (mdu_op == OP_MULTU);
    assign is_md   = is_mult || (mdu_op == OP_DIV) || (mdu_op == OP_DIVU);

    // Low 64 bits of a sign-extended product equal the signed product.
    assign prod_s = {{32{A1[31]}}, A1} * {{32{A2[31]}}, A2};
    assign prod_u = {32'd0, A1} * {32'd0, A2};

    // One unsigned divider on magnitudes; signs reapplied afterwards.
    // 0x80000000 / -1 falls out as 0x80000000 rem 0 with no special case.
    assign div_signed = (mdu_op == OP_DIV);
    assign neg_a      = div_signed & A1[31];
    assign neg_b      = div_signed & A2[31];
    assign mag_a      = neg_a ? -A1 : A1;
    assign mag_b      = neg_b ? -A2 : A2;
    assign divisor    = (mag_b == 32'd0) ? 32'd1 : mag_b;
    assign q_mag      = mag_a / divisor;
    assign r_mag      = mag_a % divisor;
    assign quot       = (neg_a ^ neg_b) ? -q_mag : q_mag;
    assign rem        = neg_a ? -r_mag : r_mag;

    always_comb begin
        state_nx = state;
        count_nx = count;
        accept   = 1'b0;
        commit   = 1'b0;
        case (state)
            IDLE: begin
                if (start && is_md) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                    count_nx = is_mult ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                end
            end
            RUN: begin
                count_nx = count - CW'(1);
                if (count == CW'(1)) begin
                    commit   = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            hi      <= '0;
            lo      <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_we <= 1'b0;
        end else begin
            state <= state_nx;
            count <= count_nx;
            if (accept) begin
                case (mdu_op)
                    OP_MULT:  {pend_hi, pend_lo} <= prod_s;
                    OP_MULTU: {pend_hi, pend_lo} <= prod_u;
                    default:  {pend_hi, pend_lo} <= {rem, quot};
                endcase
                pend_we <= is_mult || (A2 != 32'd0);
            end
            if (commit) begin
                if (pend_we) begin
                    hi <= pend_hi;
                    lo <= pend_lo;
                end
            end else if (state == IDLE && !start) begin
                if (mdu_op == OP_MTHI) hi <= A1;
                if (mdu_op == OP_MTLO) lo <= A1;
            end
        end
    end

    always_comb begin
        case (mdu_op)
            OP_MFHI: mdu_res = hi;
            OP_MFLO: mdu_res = lo;
            default: mdu_res = 32'd0;
        endcase
    end

    assign busy   = (state == RUN);
    assign hi_out = hi;
    assign lo_out = lo;

endmodule
